// File: rtl/keypad_entry_buffer_if.sv
// ---------------------------------------------------------------------------
// keypad_entry_buffer_if
// Purpose : bundles the keypad strobes, the lockout level and the passcode
//           outputs of keypad_entry_buffer into one interface.
// Ports   : key_valid/key_code/key_clear/key_enter/lock_in  -> buffer
//           pass_out/enter_out/digit_cnt/entry_err/timeout_evt <- buffer
// Modports: master = keypad/test side, slave = keypad_entry_buffer.
// ---------------------------------------------------------------------------
interface keypad_entry_buffer_if #(
    parameter int DIGITS = 3,
    parameter int DW     = 4
);
    localparam int CW = $clog2(DIGITS + 1);

    logic                 key_valid;
    logic [DW-1:0]        key_code;
    logic                 key_clear;
    logic                 key_enter;
    logic                 lock_in;
    logic [DIGITS*DW-1:0] pass_out;
    logic                 enter_out;
    logic [CW-1:0]        digit_cnt;
    logic                 entry_err;
    logic                 timeout_evt;

    modport master (
        output key_valid, key_code, key_clear, key_enter, lock_in,
        input  pass_out, enter_out, digit_cnt, entry_err, timeout_evt
    );

    modport slave (
        input  key_valid, key_code, key_clear, key_enter, lock_in,
        output pass_out, enter_out, digit_cnt, entry_err, timeout_evt
    );
endinterface

// File: rtl/keypad_entry_buffer.sv
// ---------------------------------------------------------------------------
// keypad_entry_buffer
// Purpose : collects keypad digits into a DIGITS x DW passcode word and hands
//           it to the downstream comparator with a one-cycle enter strobe.
//           Handles clear, short-entry rejection, idle timeout and lockout.
// Ports   : clk  - system clock, rising edge
//           rstn - asynchronous active-low reset
//           bus  - keypad_entry_buffer_if.slave (keys in, passcode out)
//
// state   | meaning
// --------+---------------------------------------------------
// IDLE    | no digits held (digit_cnt = 0)
// COLLECT | partial entry, 0 < digit_cnt < DIGITS
// FULL    | complete entry, digit_cnt = DIGITS, waiting enter
// LOCKED  | downstream alarm active, every key ignored
// ---------------------------------------------------------------------------
module keypad_entry_buffer #(
    parameter int DIGITS  = 3,
    parameter int DW      = 4,
    parameter int TIMEOUT = 1000
) (
    input logic                  clk,
    input logic                  rstn,
    keypad_entry_buffer_if.slave bus
);
    localparam int PW = DIGITS * DW;
    localparam int CW = $clog2(DIGITS + 1);
    localparam int IW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        FULL    = 2'd2,
        LOCKED  = 2'd3
    } state_t;

    state_t        r_state;
    logic [PW-1:0] r_pass;
    logic [CW-1:0] r_cnt;
    logic [IW-1:0] r_idle;
    logic          r_enter;
    logic          r_err;
    logic          r_tout;

    // Oldest digit falls off the top; newest lands in [DW-1:0].
    logic [PW-1:0] w_shift;
    assign w_shift = PW'({r_pass, bus.key_code});

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
            r_pass  <= '0;
            r_cnt   <= '0;
            r_idle  <= '0;
            r_enter <= 1'b0;
            r_err   <= 1'b0;
            r_tout  <= 1'b0;
        end else begin
            r_enter <= 1'b0;
            r_err   <= 1'b0;
            r_tout  <= 1'b0;

            if (bus.lock_in) begin
                r_state <= LOCKED;
                r_pass  <= '0;
                r_cnt   <= '0;
                r_idle  <= '0;
            end else if (r_state == LOCKED) begin
                // Release cycle: keys still ignored, entry restarts from IDLE.
                r_state <= IDLE;
                r_idle  <= '0;
            end else if (bus.key_clear) begin
                r_state <= IDLE;
                r_pass  <= '0;
                r_cnt   <= '0;
                r_idle  <= '0;
            end else if (bus.key_enter) begin
                r_state <= IDLE;
                r_cnt   <= '0;
                r_idle  <= '0;
                if (r_state == FULL) begin
                    // Submitted code stays in r_pass for the downstream.
                    r_enter <= 1'b1;
                end else begin
                    r_err  <= 1'b1;
                    r_pass <= '0;
                end
            end else if (bus.key_valid) begin
                // Any key strobe restarts the idle timer, so a key arriving on
                // the terminal count always beats the timeout.
                r_idle <= '0;
                if (r_state == FULL) begin
                    r_err <= 1'b1;
                end else begin
                    r_pass  <= w_shift;
                    r_cnt   <= r_cnt + CW'(1);
                    r_state <= (r_cnt == CW'(DIGITS - 1)) ? FULL : COLLECT;
                end
            end else if (r_state == COLLECT || r_state == FULL) begin
                if (r_idle == IW'(TIMEOUT - 1)) begin
                    r_state <= IDLE;
                    r_pass  <= '0;
                    r_cnt   <= '0;
                    r_idle  <= '0;
                    r_tout  <= 1'b1;
                end else begin
                    r_idle <= r_idle + IW'(1);
                end
            end else begin
                r_idle <= '0;
            end
        end
    end

    assign bus.pass_out    = r_pass;
    assign bus.enter_out   = r_enter;
    assign bus.digit_cnt   = r_cnt;
    assign bus.entry_err   = r_err;
    assign bus.timeout_evt = r_tout;
endmodule
